// File: rtl/calc_bcd_display.sv
// calc_bcd_display
//   Board-level calculator: debounces three active-low keys, latches two
//   operands from the switches, adds/subtracts/multiplies them, shows the
//   binary result on LEDR and the signed decimal result on DIGITS
//   seven-segment displays via a multi-cycle double-dabble converter.
//
// Ports
//   CLOCK_50  in   system clock (rising edge)
//   RST_N     in   asynchronous active-low reset
//   SW        in   {A, B} operands, each OPW bits
//   KEY       in   active-low buttons: [0] add, [1] subtract, [2] multiply
//   LEDR      out  registered binary result (two's complement for subtract)
//   HEX       out  digit i on HEX[7i+6:7i], active-low, bit0 = a .. bit6 = g
//   BUSY      out  high while an operation is in progress
//   NEG       out  last subtract result was negative
//   OVF       out  last magnitude not displayable in DIGITS digits
module calc_bcd_display #(
    parameter int OPW        = 5,
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    input  logic [2*OPW-1:0]      SW,
    input  logic [2:0]            KEY,
    output logic [2*OPW-1:0]      LEDR,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  BUSY,
    output logic                  NEG,
    output logic                  OVF
);
    localparam int RW  = 2 * OPW;
    localparam int BW  = 4 * DIGITS + 4;          // one spare nibble flags overflow
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int CCW = $clog2(RW + 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    function automatic logic [7*DIGITS-1:0] hex_reset();
        logic [7*DIGITS-1:0] h;
        for (int i = 0; i < DIGITS; i++)
            h[7*i +: 7] = (i == 0) ? SEG_ZERO : SEG_BLANK;
        return h;
    endfunction

    localparam logic [7*DIGITS-1:0] HEX_RST = hex_reset();

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Key conditioning: 2-flop synchroniser, then a debouncer that only
    // follows the input after DEB_CYCLES consecutive differing samples.
    // ------------------------------------------------------------------
    logic [2:0]     r_sync1, r_sync2, r_stable, r_press;
    logic [DCW-1:0] r_deb_cnt [3];

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_stable <= '1;
            r_press  <= '0;
            for (int k = 0; k < 3; k++) r_deb_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                r_press[k] <= 1'b0;
                if (r_sync2[k] != r_stable[k]) begin
                    if (r_deb_cnt[k] == DCW'(DEB_CYCLES - 1)) begin
                        r_stable[k]  <= r_sync2[k];
                        r_deb_cnt[k] <= '0;
                        r_press[k]   <= ~r_sync2[k];  // pulse on accepted press only
                    end else begin
                        r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                    end
                end else begin
                    r_deb_cnt[k] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_SHOW} state_t;

    state_t         r_state, w_next;
    logic [CCW-1:0] r_conv_cnt;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|r_press) w_next = S_CALC;
            S_CALC:  w_next = S_CONV;
            S_CONV:  if (r_conv_cnt == CCW'(RW - 1)) w_next = S_SHOW;
            S_SHOW:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign BUSY = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    logic [OPW-1:0] r_a, r_b;
    logic [1:0]     r_op;
    logic [RW-1:0]  w_a_ext, w_b_ext, w_result, w_mag;
    logic           w_neg;

    always_comb begin
        w_a_ext = {{OPW{1'b0}}, r_a};
        w_b_ext = {{OPW{1'b0}}, r_b};
        case (r_op)
            OP_ADD:  w_result = w_a_ext + w_b_ext;
            OP_SUB:  w_result = w_a_ext - w_b_ext;
            default: w_result = w_a_ext * w_b_ext;
        endcase
        w_neg = (r_op == OP_SUB) && (r_a < r_b);
        w_mag = w_neg ? (w_b_ext - w_a_ext) : w_result;
    end

    // ------------------------------------------------------------------
    // Double dabble: add 3 to every nibble >= 5, then shift in next bit.
    // ------------------------------------------------------------------
    logic [RW-1:0] r_bin;
    logic [BW-1:0] r_bcd, w_adj;
    logic          r_lost;   // a 1 fell off the top of the BCD register

    always_comb begin
        w_adj = r_bcd;
        for (int n = 0; n <= DIGITS; n++)
            if (r_bcd[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end

    // ------------------------------------------------------------------
    // Display formatting from the finished BCD value
    // ------------------------------------------------------------------
    logic [DIGITS:0]          w_shown;   // w_shown[i+1]: digit i is displayed
    logic [7*DIGITS-1:0]      w_hex;
    logic                     w_ovf;

    always_comb begin
        logic seen;
        seen    = 1'b0;
        w_shown = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen         = seen | (r_bcd[4*i +: 4] != 4'd0);
            w_shown[i+1] = seen;
        end
        w_shown[1] = 1'b1;   // digit 0 always visible
        // A negative number needs a free digit for its sign.
        w_ovf = r_lost | (r_bcd[BW-1 -: 4] != 4'd0)
              | (NEG & (r_bcd[4*DIGITS-1 -: 4] != 4'd0));
        w_hex = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ovf)                    w_hex[7*i +: 7] = SEG_DASH;
            else if (w_shown[i+1])        w_hex[7*i +: 7] = seg7(r_bcd[4*i +: 4]);
            else if (NEG && w_shown[i])   w_hex[7*i +: 7] = SEG_DASH;
            else                          w_hex[7*i +: 7] = SEG_BLANK;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_lost     <= 1'b0;
            r_conv_cnt <= '0;
            LEDR       <= '0;
            NEG        <= 1'b0;
            OVF        <= 1'b0;
            HEX        <= HEX_RST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|r_press) begin
                        r_a  <= SW[2*OPW-1:OPW];
                        r_b  <= SW[OPW-1:0];
                        r_op <= r_press[0] ? OP_ADD : (r_press[1] ? OP_SUB : OP_MUL);
                    end
                end
                S_CALC: begin
                    LEDR       <= w_result;
                    NEG        <= w_neg;
                    r_bin      <= w_mag;
                    r_bcd      <= '0;
                    r_lost     <= 1'b0;
                    r_conv_cnt <= '0;
                end
                S_CONV: begin
                    r_bcd      <= {w_adj[BW-2:0], r_bin[RW-1]};
                    r_bin      <= r_bin << 1;
                    r_lost     <= r_lost | w_adj[BW-1];
                    r_conv_cnt <= r_conv_cnt + 1'b1;
                end
                S_SHOW: begin
                    HEX <= w_hex;
                    OVF <= w_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule
